// File: rtl/proc_test_sequencer_pkg.sv
// Shared types for the multi-program run controller: FSM state encoding and slot indexing.
// Optional STALL_DETECT_EN (see proc_test_sequencer.sv) needs nothing from this package.
package proc_test_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam int SLOT_IDX_W = 4;
  localparam int MAX_SLOTS  = 16;

  function automatic logic [SLOT_IDX_W-1:0] slot_idx(input int i);
    return SLOT_IDX_W'(i);
  endfunction

endpackage

// File: rtl/proc_test_sequencer_watchdog.sv
// cycle_watchdog: saturating run-cycle counter with a limit flag that fires in the cycle
// whose increment reaches WD_LIMIT, so the owner can leave on exactly WD_LIMIT cycles.
module cycle_watchdog #(
  parameter int unsigned WDW      = 16,
  parameter int unsigned WD_LIMIT = 16'hFF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           enable,
  output logic [WDW-1:0] count,
  output logic           expired
);

  localparam logic [WDW-1:0] LIM = WDW'(WD_LIMIT);

  logic [WDW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIM)) begin
      count_d = count_q + WDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = enable && !clear && (count_d == LIM);

endmodule

// File: rtl/proc_test_sequencer.sv
// Runs NPROG programs on the single-cycle core back to back, recording pass/timeout/cycles.
// Build option STALL_DETECT_EN: an unchanged PC for STALL_LIM RUN cycles ends the run as a timeout.
//
// state   | meaning
// S_IDLE  | after reset, core held in reset, waiting for start
// S_RST   | core reset low for RST_CYC cycles, start PC presented
// S_RUN   | core running, watchdog counting, waiting for final PC
// S_CHECK | compare writeback value, record cycle count
// S_NEXT  | core back in reset, advance slot or finish
// S_DONE  | results valid, waiting for next start
module proc_test_sequencer
  import proc_test_sequencer_pkg::*;
#(
  parameter int unsigned NPROG     = 4,
  parameter int unsigned AW        = 64,
  parameter int unsigned WDW       = 16,
  parameter int unsigned WD_LIMIT  = 16'hFF,
  parameter int unsigned RST_CYC   = 2,
  parameter int unsigned STALL_LIM = 8
) (
  input  logic                  CLK,
  input  logic                  resetl,
  input  logic                  start,
  input  logic [NPROG*AW-1:0]   prog_startpc,
  input  logic [NPROG*AW-1:0]   prog_finalpc,
  input  logic [NPROG*AW-1:0]   prog_expect,
  input  logic [AW-1:0]         currentpc,
  input  logic [AW-1:0]         MemtoRegOut,
  output logic                  cpu_resetl,
  output logic [AW-1:0]         cpu_startpc,
  output logic                  busy,
  output logic                  done,
  output logic [SLOT_IDX_W-1:0] cur_prog,
  output logic [NPROG-1:0]      pass_mask,
  output logic [NPROG-1:0]      timeout_mask,
  output logic [WDW-1:0]        last_cycles
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0]        RST_LAST  = RCW'(RST_CYC - 1);
  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(NPROG - 1);

  state_e                  state_q, state_d;
  logic [SLOT_IDX_W-1:0]   cur_prog_q, cur_prog_d;
  logic [RCW-1:0]          rst_cnt_q, rst_cnt_d;
  logic                    cpu_resetl_q, cpu_resetl_d;
  logic [AW-1:0]           cpu_startpc_q, cpu_startpc_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [NPROG-1:0]        pass_mask_q, pass_mask_d;
  logic [NPROG-1:0]        timeout_mask_q, timeout_mask_d;
  logic [WDW-1:0]          last_cycles_q, last_cycles_d;

  logic [NPROG-1:0]        slot_oh;
  logic [AW-1:0]           sel_finalpc, sel_expect, nxt_startpc;
  logic [SLOT_IDX_W-1:0]   nxt_prog;
  logic [WDW-1:0]          wd_count;
  logic                    wd_expired;
  logic                    run_complete;
  logic                    stall_hit;

  assign nxt_prog = cur_prog_q + SLOT_IDX_W'(1);

  always_comb begin
    slot_oh     = '0;
    sel_finalpc = '0;
    sel_expect  = '0;
    nxt_startpc = '0;
    for (int i = 0; i < int'(NPROG); i++) begin
      if (cur_prog_q == slot_idx(i)) begin
        slot_oh[i]  = 1'b1;
        sel_finalpc = prog_finalpc[i*AW +: AW];
        sel_expect  = prog_expect[i*AW +: AW];
      end
      if (nxt_prog == slot_idx(i)) begin
        nxt_startpc = prog_startpc[i*AW +: AW];
      end
    end
  end

  cycle_watchdog #(
    .WDW      (WDW),
    .WD_LIMIT (WD_LIMIT)
  ) u_watchdog (
    .clk     (CLK),
    .rst_n   (resetl),
    .clear   (state_q == S_RST),
    .enable  (state_q == S_RUN),
    .count   (wd_count),
    .expired (wd_expired)
  );

  assign run_complete = (currentpc >= sel_finalpc);

`ifdef STALL_DETECT_EN
  localparam int SCW = $clog2(STALL_LIM + 1);

  logic [AW-1:0]  prev_pc_q, prev_pc_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

  // Counts identical-PC RUN cycles including the current one; restarts at 1 on any change.
  always_comb begin
    prev_pc_d   = prev_pc_q;
    stall_cnt_d = '0;
    if (state_q == S_RUN) begin
      prev_pc_d = currentpc;
      if ((stall_cnt_q == '0) || (currentpc != prev_pc_q)) begin
        stall_cnt_d = SCW'(1);
      end else if (stall_cnt_q != SCW'(STALL_LIM)) begin
        stall_cnt_d = stall_cnt_q + SCW'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      prev_pc_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      prev_pc_q   <= prev_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_hit = (state_q == S_RUN) && (stall_cnt_d == SCW'(STALL_LIM));
`else
  logic unused_stall_lim;
  assign unused_stall_lim = ^32'(STALL_LIM);
  assign stall_hit        = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cur_prog_d     = cur_prog_q;
    rst_cnt_d      = rst_cnt_q;
    cpu_startpc_d  = cpu_startpc_q;
    pass_mask_d    = pass_mask_q;
    timeout_mask_d = timeout_mask_q;
    last_cycles_d  = last_cycles_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d        = S_RST;
          cur_prog_d     = '0;
          rst_cnt_d      = '0;
          cpu_startpc_d  = prog_startpc[AW-1:0];
          pass_mask_d    = '0;
          timeout_mask_d = '0;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      S_RUN: begin
        // Completion takes priority over a limit hit in the same cycle.
        if (run_complete) begin
          state_d = S_CHECK;
        end else if (wd_expired || stall_hit) begin
          state_d        = S_NEXT;
          timeout_mask_d = timeout_mask_q | slot_oh;
          pass_mask_d    = pass_mask_q & ~slot_oh;
          last_cycles_d  = wd_count + WDW'(1);
        end
      end
      S_CHECK: begin
        state_d       = S_NEXT;
        last_cycles_d = wd_count;
        if (MemtoRegOut == sel_expect) begin
          pass_mask_d = pass_mask_q | slot_oh;
        end else begin
          pass_mask_d = pass_mask_q & ~slot_oh;
        end
      end
      S_NEXT: begin
        if (cur_prog_q == LAST_SLOT) begin
          state_d = S_DONE;
        end else begin
          state_d       = S_RST;
          cur_prog_d    = nxt_prog;
          rst_cnt_d     = '0;
          cpu_startpc_d = nxt_startpc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_resetl_d = (state_d == S_RUN) || (state_d == S_CHECK);
    busy_d       = (state_d == S_RST) || (state_d == S_RUN) ||
                   (state_d == S_CHECK) || (state_d == S_NEXT);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q        <= S_IDLE;
      cur_prog_q     <= '0;
      rst_cnt_q      <= '0;
      cpu_resetl_q   <= 1'b0;
      cpu_startpc_q  <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_mask_q    <= '0;
      timeout_mask_q <= '0;
      last_cycles_q  <= '0;
    end else begin
      state_q        <= state_d;
      cur_prog_q     <= cur_prog_d;
      rst_cnt_q      <= rst_cnt_d;
      cpu_resetl_q   <= cpu_resetl_d;
      cpu_startpc_q  <= cpu_startpc_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_mask_q    <= pass_mask_d;
      timeout_mask_q <= timeout_mask_d;
      last_cycles_q  <= last_cycles_d;
    end
  end

  assign cpu_resetl   = cpu_resetl_q;
  assign cpu_startpc  = cpu_startpc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cur_prog     = cur_prog_q;
  assign pass_mask    = pass_mask_q;
  assign timeout_mask = timeout_mask_q;
  assign last_cycles  = last_cycles_q;

endmodule
